ao311_vector_driver: RTL and testbench
======================================

Name: ao311_vector_driver

Overview:
- Upstream stimulus stage for the ao311 cell. It drives the cell's a..e inputs through all 32 combinations and reads its z output back.
- Each sampled z is compared against the golden function z = (a&b&c)|d|e, and mismatches are tallied.
- Used as the on-chip exhaustive checker that sits directly in front of an ao311 instance. z_in is wired to the cell's z.

Parameters:
SETTLE, 2, cycles the driven vector is held before z_in is sampled; legal range 1..15

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin a run; sampled on rising clk edge
z_in  input  1  z from the ao311 under test
a  output  1  driven to ao311 a (vec[4])
b  output  1  driven to ao311 b (vec[3])
c  output  1  driven to ao311 c (vec[2])
d  output  1  driven to ao311 d (vec[1])
e  output  1  driven to ao311 e (vec[0])
busy  output  1  run in progress
done  output  1  run complete; held until next start or reset
pass  output  1  done && err_cnt==0
err_cnt  output  6  number of mismatching vectors (0..32)
fail_seen  output  1  at least one mismatch recorded this run
first_fail  output  5  vector index of the first mismatch

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, vec=0 (so a..e=0), wait_cnt=0, busy=0, done=0, pass=0, err_cnt=0, fail_seen=0, first_fail=0. Asserting rst mid-run aborts immediately to these values. No partial results are retained.
- Registered outputs: a..e are registered copies of vec[4:0]; a=vec[4], e=vec[0]. No combinational path from z_in to any output.
- State IDLE / DONE, start=1 sampled:
  - vec<=0, err_cnt<=0, fail_seen<=0, first_fail<=0, done<=0, pass<=0.
  - busy<=1, wait_cnt<=SETTLE-1, state<=WAIT.
  - start=0 in these states: hold.
- State WAIT:
  - wait_cnt==0 -> state<=CHECK.
  - Otherwise wait_cnt<=wait_cnt-1.
  - WAIT occupies exactly SETTLE cycles per vector.
- State CHECK (1 cycle): expected = (vec[4]&vec[3]&vec[2])|vec[1]|vec[0].
  - On z_in != expected: err_cnt<=err_cnt+1. If fail_seen==0, also first_fail<=vec and fail_seen<=1.
  - vec==31: state<=DONE, busy<=0, done<=1, pass<=(final err_cnt==0). The final count includes this cycle's compare.
  - Otherwise vec<=vec+1, wait_cnt<=SETTLE-1, state<=WAIT.
- Timing: each vector takes SETTLE+1 cycles. done rises on the 32*(SETTLE+1)-th rising edge after the edge that sampled start (96 for SETTLE=2).
- start while busy: ignored; no restart, no counter change.
- Width rules:
  - err_cnt is 6 bits, so its maximum of 32 needs no saturation.
  - vec is 5 bits and never wraps within a run; the run ends at 31.
- DONE: a..e hold vector 31 (all ones). Results stay stable until start or rst.
- Golden totals: the function is 1 for 25 of the 32 vectors and 0 for 7 (vectors 0, 4, 8, 12, 16, 20, 24).

Test Plan:
- Correct ao311 model on z_in, SETTLE=2, pulse start -> done=1 exactly 96 edges later; err_cnt=0, pass=1, fail_seen=0.
- z_in tied 0 -> err_cnt=25, first_fail=1 (vector 00001 expects 1), fail_seen=1, pass=0.
- z_in tied 1 -> err_cnt=7, first_fail=0, pass=0.
- Faulty model z=(a&b&c)|d (e dropped) -> err_cnt=7, first_fail=1. Mismatching vectors are 1, 5, 9, 13, 17, 21, 25.
- Reset and start handling:
  - Assert rst asynchronously mid-run (vector 10) -> all outputs 0 immediately, without waiting for a clock edge.
  - A start pulse during busy is ignored; the run still finishes on schedule.
  - start after done clears results and reruns with identical output.
- SETTLE=1 with correct model -> done at edge 64. Each of a..e holds for 2 cycles per vector; vector order 0..31 is checked by monitor.

Source files
------------

// File: rtl/ao311_vector_driver.sv
// Exhaustive stimulus driver and checker for an ao311 cell: walks a..e through all
// 32 vectors, samples z after a settle delay and tallies mismatches against the golden function.
module ao311_vector_driver #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       z_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_cnt,
  output logic       fail_seen,
  output logic [4:0] first_fail
);

  // state | meaning
  // IDLE  | out of reset, waiting for start
  // WAIT  | vector driven, settle timer counting down
  // CHECK | sample z_in and compare against golden value
  // DONE  | run complete, results held until start or rst
  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [4:0] vec_q, vec_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [5:0] err_cnt_q, err_cnt_d;
  logic       fail_seen_q, fail_seen_d;
  logic [4:0] first_fail_q, first_fail_d;

  logic       golden;
  logic       mismatch;
  logic [5:0] err_next;

  assign golden   = (vec_q[4] & vec_q[3] & vec_q[2]) | vec_q[1] | vec_q[0];
  assign mismatch = (z_in != golden);
  assign err_next = err_cnt_q + {5'd0, mismatch};

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    wait_cnt_d   = wait_cnt_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    err_cnt_d    = err_cnt_q;
    fail_seen_d  = fail_seen_q;
    first_fail_d = first_fail_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          vec_d        = 5'd0;
          err_cnt_d    = 6'd0;
          fail_seen_d  = 1'b0;
          first_fail_d = 5'd0;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          busy_d       = 1'b1;
          wait_cnt_d   = SETTLE_M1;
          state_d      = WAIT;
        end
      end

      WAIT: begin
        if (wait_cnt_q == 4'd0) state_d = CHECK;
        else                    wait_cnt_d = wait_cnt_q - 4'd1;
      end

      CHECK: begin
        err_cnt_d = err_next;
        if (mismatch && !fail_seen_q) begin
          first_fail_d = vec_q;
          fail_seen_d  = 1'b1;
        end
        if (vec_q == 5'd31) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // pass must reflect the compare made in this very cycle
          pass_d  = (err_next == 6'd0);
        end else begin
          vec_d      = vec_q + 5'd1;
          wait_cnt_d = SETTLE_M1;
          state_d    = WAIT;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      vec_q        <= 5'd0;
      wait_cnt_q   <= 4'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_cnt_q    <= 6'd0;
      fail_seen_q  <= 1'b0;
      first_fail_q <= 5'd0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      wait_cnt_q   <= wait_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_cnt_q    <= err_cnt_d;
      fail_seen_q  <= fail_seen_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign a          = vec_q[4];
  assign b          = vec_q[3];
  assign c          = vec_q[2];
  assign d          = vec_q[1];
  assign e          = vec_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_cnt_q;
  assign fail_seen  = fail_seen_q;
  assign first_fail = first_fail_q;

endmodule

// File: tb/tb_ao311_vector_driver.sv
// Directed bench for ao311_vector_driver: cell models on z_in, run latency,
// result totals, async abort, start-while-busy, rerun and SETTLE=1 vector ordering.
module tb_ao311_vector_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start1 = 1'b0;
  int   mode = 0;   // 0 good cell, 1 z stuck 0, 2 z stuck 1, 3 e input dropped

  logic z, a, b, c, d, e, busy, done, pass, fail_seen;
  logic [5:0] err_cnt;
  logic [4:0] first_fail;

  logic z1, a1, b1, c1, d1, e1, busy1, done1, pass1, fail_seen1;
  logic [5:0] err_cnt1;
  logic [4:0] first_fail1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      0:       z = (a & b & c) | d | e;
      1:       z = 1'b0;
      2:       z = 1'b1;
      3:       z = (a & b & c) | d;
      default: z = 1'b0;
    endcase
  end

  assign z1 = (a1 & b1 & c1) | d1 | e1;

  ao311_vector_driver #(.SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .z_in(z),
    .a(a), .b(b), .c(c), .d(d), .e(e),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_seen(fail_seen), .first_fail(first_fail)
  );

  ao311_vector_driver #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .z_in(z1),
    .a(a1), .b(b1), .c(c1), .d(d1), .e(e1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err_cnt1),
    .fail_seen(fail_seen1), .first_fail(first_fail1)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int vec_now();
    return int'({a, b, c, d, e});
  endfunction

  // Pulse start, then count edges until done; optional extra start pulse mid-run.
  task automatic run(input string tag, input int m, input int exp_err, input int exp_ff,
                     input int exp_fs, input int exp_pass, input int mid_start);
    int n;
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_rise"}, busy, 1);
    check({tag, "_done_clr"}, done, 0);
    check({tag, "_err_clr"}, err_cnt, 0);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (start) start = 1'b0;
      if (done) begin n = i; break; end
      if (i == mid_start) start = 1'b1;
    end
    check({tag, "_latency"}, n, 96);
    check({tag, "_err_cnt"}, err_cnt, exp_err);
    check({tag, "_first_fail"}, first_fail, exp_ff);
    check({tag, "_fail_seen"}, fail_seen, exp_fs);
    check({tag, "_pass"}, pass, exp_pass);
    check({tag, "_busy_fall"}, busy, 0);
    check({tag, "_vec_hold"}, vec_now(), 31);
  endtask

  initial begin
    int n, prev, hold, viol;

    #22 rst = 1'b0;
    #1;
    check("rst_vec", vec_now(), 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_cnt, 0);
    check("rst_fs", fail_seen, 0);
    check("rst_ff", first_fail, 0);

    run("good", 0, 0, 0, 0, 1, 0);
    run("stuck0", 1, 25, 1, 1, 0, 0);
    run("stuck1", 2, 7, 0, 1, 0, 0);
    run("drop_e", 3, 7, 1, 1, 0, 0);
    run("busy_start", 0, 0, 0, 0, 1, 40);
    run("rerun_a", 1, 25, 1, 1, 0, 0);
    run("rerun_b", 1, 25, 1, 1, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("done_hold", done, 1);
    check("done_hold_err", err_cnt, 25);

    // Abort mid-run at vector 10 with the stuck-0 model
    @(negedge clk);
    mode  = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (vec_now() == 10) begin n = i; break; end
    end
    check("abort_reach_v10", (n > 0) ? 1 : 0, 1);
    check("abort_pre_err", err_cnt, 7);
    #2 rst = 1'b1;
    #1;
    check("abort_vec", vec_now(), 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_pass", pass, 0);
    check("abort_err", err_cnt, 0);
    check("abort_fs", fail_seen, 0);
    check("abort_ff", first_fail, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_stays_idle", busy, 0);

    // SETTLE=1: 64-edge run, each vector held two cycles, in order 0..31
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    prev = int'({a1, b1, c1, d1, e1});
    hold = 1;
    viol = 0;
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      int cur;
      @(posedge clk); #1;
      if (done1) begin n = i; break; end
      cur = int'({a1, b1, c1, d1, e1});
      if (cur == prev) hold++;
      else begin
        if (cur != prev + 1 || hold != 2) viol++;
        prev = cur;
        hold = 1;
      end
    end
    check("s1_start_vec_first", (prev == 31 && hold == 2) ? 1 : 0, 1);
    check("s1_order_viol", viol, 0);
    check("s1_latency", n, 64);
    check("s1_err", err_cnt1, 0);
    check("s1_pass", pass1, 1);
    check("s1_fs", fail_seen1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
